// File: rtl/sha3_range_scanner.sv
// Nonce range scanner: issues one Keccak candidate state per cycle into an external
// fixed-latency permutation pipeline and pushes threshold hits into a small result FIFO.
module sha3_range_scanner #(
  parameter int          RESULT_DEPTH = 4,
  parameter int          HASH_LANES   = 4,
  parameter logic [31:0] DOMAIN_PAD   = 32'h0000_0006
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        stop_on_first,
  input  logic [23:0][31:0]           header,
  input  logic [31:0]                 start_nonce,
  input  logic [31:0]                 nonce_count,
  input  logic [63:0]                 threshold,
  output logic                        perm_in_valid,
  output logic [24:0][63:0]           perm_in_state,
  input  logic                        perm_out_valid,
  input  logic [24:0][63:0]           perm_out_state,
  output logic                        ready,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [32:0]                 scanned,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [31:0]                 res_nonce,
  output logic [HASH_LANES-1:0][63:0] res_hash
);
  localparam int AW = $clog2(RESULT_DEPTH);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [11:0][63:0] hdr_q;
  logic [31:0]       base_q;
  logic [32:0]       count_q;
  logic [63:0]       thr_q;
  logic              sof_q;
  logic [32:0]       issued_q, issued_d;
  logic [32:0]       scanned_q, scanned_d;
  logic              ovf_q, ovf_d;
  logic              hit_q, hit_d;
  logic              done_q, done_d;
  logic [AW:0]       wp_q, rp_q;
  logic              capture, push, pop, full, stop_issue, eval, is_hit;
  logic [63:0]       difficulty;
  logic [31:0]       issue_nonce;
  logic              unused_bits;

  logic [31:0]                 mem_nonce [RESULT_DEPTH];
  logic [HASH_LANES-1:0][63:0] mem_hash  [RESULT_DEPTH];

  assign full       = (wp_q - rp_q) == (AW+1)'(RESULT_DEPTH);
  assign res_valid  = wp_q != rp_q;
  assign pop        = res_valid & res_ready;
  assign stop_issue = (issued_q == count_q) | abort | ovf_q | (sof_q & hit_q);
  assign eval       = perm_out_valid & (state_q != IDLE);
  assign issue_nonce = base_q + issued_q[31:0];
  assign unused_bits = ^perm_out_state;

  // Difficulty is lane 0 read as big-endian bytes: lane0[7:0] is the MSB.
  always_comb begin
    for (int b = 0; b < 8; b++) difficulty[63-8*b -: 8] = perm_out_state[0][8*b +: 8];
  end
  assign is_hit = eval & (difficulty < thr_q);

  always_comb begin
    perm_in_state     = '0;
    perm_in_state[11:0] = hdr_q;
    perm_in_state[12] = {DOMAIN_PAD, issue_nonce};
    perm_in_state[16] = 64'h8000_0000_0000_0000;
  end
  assign perm_in_valid = (state_q == DISPATCH) & ~stop_issue;

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    scanned_d = scanned_q + 33'(eval);
    ovf_d     = ovf_q;
    hit_d     = hit_q;
    done_d    = 1'b0;
    capture   = 1'b0;
    push      = 1'b0;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    if (is_hit) begin
      if (!sof_q || !hit_q) begin
        if (!full || pop) push = 1'b1;
        else              ovf_d = 1'b1;
      end
      if (sof_q) hit_d = 1'b1;
    end
    case (state_q)
      IDLE: if (start) begin
        state_d   = DISPATCH;
        capture   = 1'b1;
        issued_d  = '0;
        scanned_d = '0;
        ovf_d     = 1'b0;
        hit_d     = 1'b0;
      end
      DISPATCH: begin
        if (stop_issue) state_d  = DRAIN;
        else            issued_d = issued_q + 33'd1;
      end
      DRAIN: if (scanned_d == issued_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hdr_q     <= '0;
      base_q    <= '0;
      count_q   <= '0;
      thr_q     <= '0;
      sof_q     <= 1'b0;
      issued_q  <= '0;
      scanned_q <= '0;
      ovf_q     <= 1'b0;
      hit_q     <= 1'b0;
      done_q    <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      scanned_q <= scanned_d;
      ovf_q     <= ovf_d;
      hit_q     <= hit_d;
      done_q    <= done_d;
      if (capture) begin
        hdr_q   <= header;
        base_q  <= start_nonce;
        count_q <= (nonce_count == 32'd0) ? 33'h1_0000_0000 : {1'b0, nonce_count};
        thr_q   <= threshold;
        sof_q   <= stop_on_first;
      end
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_nonce[wp_q[AW-1:0]] <= base_q + scanned_q[31:0];
      mem_hash[wp_q[AW-1:0]]  <= perm_out_state[HASH_LANES-1:0];
    end
  end

  assign ready     = state_q == IDLE;
  assign busy      = ~ready;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign scanned   = scanned_q;
  assign res_nonce = mem_nonce[rp_q[AW-1:0]];
  assign res_hash  = mem_hash[rp_q[AW-1:0]];
endmodule

// File: tb/tb_sha3_range_scanner.sv
// Directed bench for sha3_range_scanner with a 5-stage identity permutation stub.
module tb_sha3_range_scanner;
  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort, stop_on_first;
  logic [23:0][31:0] hdr;
  logic [31:0]       start_nonce, nonce_count;
  logic [63:0]       threshold;
  logic              perm_in_valid;
  logic [24:0][63:0] perm_in_state;
  logic              perm_out_valid;
  logic [24:0][63:0] perm_out_state;
  logic              ready, busy, done, overflow;
  logic [32:0]       scanned;
  logic              res_valid, res_ready;
  logic [31:0]       res_nonce;
  logic [3:0][63:0]  res_hash;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int shape_err = 0;
  logic [31:0] iss_n[$];
  logic [31:0] got_n[$];
  logic [63:0] got_h0[$];

  logic [4:0]        pv = '0;
  logic [24:0][63:0] ps [5];

  sha3_range_scanner #(.RESULT_DEPTH(4), .HASH_LANES(4), .DOMAIN_PAD(32'h6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stop_on_first(stop_on_first),
    .header(hdr), .start_nonce(start_nonce), .nonce_count(nonce_count), .threshold(threshold),
    .perm_in_valid(perm_in_valid), .perm_in_state(perm_in_state),
    .perm_out_valid(perm_out_valid), .perm_out_state(perm_out_state),
    .ready(ready), .busy(busy), .done(done), .overflow(overflow), .scanned(scanned),
    .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce), .res_hash(res_hash)
  );

  always #5 clk = ~clk;

  // Hasher stub: identity permutation, latency 5, never reset (stale data survives reset).
  always @(posedge clk) begin
    pv    <= {pv[3:0], perm_in_valid};
    ps[0] <= perm_in_state;
    for (int k = 1; k < 5; k++) ps[k] <= ps[k-1];
  end
  assign perm_out_valid = pv[4];
  assign perm_out_state = ps[4];

  // Recorder: issued nonces, candidate-state shape errors, popped results, done pulses.
  always @(posedge clk) begin
    if (rst_n) begin
      if (perm_in_valid === 1'b1) begin
        iss_n.push_back(perm_in_state[12][31:0]);
        if (perm_in_state[11:0] !== hdr || perm_in_state[12][63:32] !== 32'h6 ||
            perm_in_state[16] !== 64'h8000_0000_0000_0000)
          shape_err++;
        for (int k = 13; k < 25; k++)
          if (k != 16 && perm_in_state[k] !== 64'd0) shape_err++;
      end
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        got_n.push_back(res_nonce);
        got_h0.push_back(res_hash[0]);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic clear_logs();
    iss_n.delete(); got_n.delete(); got_h0.delete();
    done_cnt = 0; shape_err = 0;
  endtask

  task automatic start_job(input logic [31:0] sn, input logic [31:0] cnt,
                           input logic [63:0] thr, input logic sof);
    @(negedge clk);
    clear_logs();
    start_nonce = sn; nonce_count = cnt; threshold = thr; stop_on_first = sof; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of clock edges after the accept edge before done is seen.
  task automatic wait_done(output int e);
    e = 0;
    while (done !== 1'b1 && e < 3000) begin
      @(negedge clk);
      e++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout: done=%b after %0d cycles, want 1", done, e);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    vectors++; if (scanned !== 33'd0) begin miscompares++; $display("FAIL rst_scanned: got %0d want 0", scanned); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    vectors++; if (perm_in_valid !== 1'b0) begin miscompares++; $display("FAIL rst_perm_in_valid: got %b want 0", perm_in_valid); end
  endtask

  task automatic test_collect_all();
    int e;
    start_job(32'd100, 32'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ca_busy: got %b want 1", busy); end
    wait_done(e);
    vectors++; if (e != 8) begin miscompares++; $display("FAIL ca_done_latency: got %0d want 8", e); end
    vectors++;
    if (got_n.size() != 3 || got_n[0] !== 32'd100 || got_n[1] !== 32'd101 || got_n[2] !== 32'd102) begin
      miscompares++; $display("FAIL ca_nonces: got %p want 100,101,102", got_n);
    end
    vectors++;
    if (got_h0.size() < 1 || got_h0[0] !== 64'h1000_0001_1000_0000) begin
      miscompares++; $display("FAIL ca_hash0: got %p want 1000000110000000", got_h0);
    end
    vectors++; if (scanned !== 33'd3) begin miscompares++; $display("FAIL ca_scanned: got %0d want 3", scanned); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL ca_done_pulses: got %0d want 1", done_cnt); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ca_overflow: got %b want 0", overflow); end
    vectors++; if (shape_err != 0) begin miscompares++; $display("FAIL ca_state_shape: got %0d bad issues want 0", shape_err); end
  endtask

  task automatic test_no_hits();
    int e;
    start_job(32'd7, 32'd10, 64'd0, 1'b0);
    wait_done(e);
    vectors++; if (got_n.size() != 0) begin miscompares++; $display("FAIL nh_results: got %0d want 0", got_n.size()); end
    vectors++; if (scanned !== 33'd10) begin miscompares++; $display("FAIL nh_scanned: got %0d want 10", scanned); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL nh_done_pulses: got %0d want 1", done_cnt); end
  endtask

  // lane0 = 1 reads as difficulty 0x0100_0000_0000_0000 after the byte reversal.
  task automatic test_threshold_boundary();
    int e;
    hdr[0] = 32'h1; hdr[1] = 32'h0;
    start_job(32'd50, 32'd1, 64'h0100_0000_0000_0000, 1'b0);
    wait_done(e);
    vectors++; if (got_n.size() != 0) begin miscompares++; $display("FAIL tb_equal_is_miss: got %0d results want 0", got_n.size()); end
    start_job(32'd50, 32'd1, 64'h0100_0000_0000_0001, 1'b0);
    wait_done(e);
    vectors++;
    if (got_n.size() != 1 || got_h0[0] !== 64'h1) begin
      miscompares++; $display("FAIL tb_above_is_hit: got %0d results want 1 with lane0=1", got_n.size());
    end
    hdr[0] = 32'h1000_0000; hdr[1] = 32'h1000_0001;
  endtask

  task automatic test_stop_first();
    int e;
    start_job(32'd500, 32'd100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_done(e);
    vectors++;
    if (got_n.size() != 1 || got_n[0] !== 32'd500) begin
      miscompares++; $display("FAIL sof_result: got %p want single 500", got_n);
    end
    vectors++; if (iss_n.size() > 7) begin miscompares++; $display("FAIL sof_issued: got %0d want <=7", iss_n.size()); end
    vectors++;
    if (scanned !== 33'(iss_n.size())) begin
      miscompares++; $display("FAIL sof_scanned: got %0d want %0d", scanned, iss_n.size());
    end
  endtask

  // FIFO fills after 4 hits, the 5th sets overflow; issue stops once overflow registers.
  task automatic test_overflow();
    int e;
    res_ready = 1'b0;
    start_job(32'd1000, 32'd20, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_done(e);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ov_flag: got %b want 1", overflow); end
    vectors++; if (iss_n.size() != 10) begin miscompares++; $display("FAIL ov_issued: got %0d want 10", iss_n.size()); end
    vectors++; if (scanned !== 33'd10) begin miscompares++; $display("FAIL ov_scanned: got %0d want 10", scanned); end
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL ov_res_valid: got %b want 1", res_valid); end
    @(negedge clk); res_ready = 1'b1;
    repeat (8) @(negedge clk);
    vectors++;
    if (got_n.size() != 4 || got_n[0] !== 32'd1000 || got_n[1] !== 32'd1001 ||
        got_n[2] !== 32'd1002 || got_n[3] !== 32'd1003) begin
      miscompares++; $display("FAIL ov_pop_order: got %p want 1000..1003", got_n);
    end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL ov_empty: got %b want 0", res_valid); end
  endtask

  task automatic test_wrap();
    int e;
    start_job(32'hFFFF_FFFE, 32'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_done(e);
    vectors++;
    if (got_n.size() != 4 || got_n[0] !== 32'hFFFF_FFFE || got_n[1] !== 32'hFFFF_FFFF ||
        got_n[2] !== 32'h0 || got_n[3] !== 32'h1) begin
      miscompares++; $display("FAIL wr_results: got %p want fffffffe,ffffffff,0,1", got_n);
    end
    vectors++;
    if (iss_n.size() != 4 || iss_n[0] !== 32'hFFFF_FFFE || iss_n[1] !== 32'hFFFF_FFFF ||
        iss_n[2] !== 32'h0 || iss_n[3] !== 32'h1) begin
      miscompares++; $display("FAIL wr_issue_lane12: got %p want fffffffe,ffffffff,0,1", iss_n);
    end
    vectors++; if (shape_err != 0) begin miscompares++; $display("FAIL wr_state_shape: got %0d want 0", shape_err); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL wr_overflow_cleared: got %b want 0", overflow); end
  endtask

  task automatic test_abort();
    int e;
    start_job(32'd2000, 32'd100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(negedge clk); @(negedge clk);
    abort = 1'b1;
    #1;
    vectors++; if (perm_in_valid !== 1'b0) begin miscompares++; $display("FAIL ab_valid_drop: got %b want 0", perm_in_valid); end
    wait_done(e);
    abort = 1'b0;
    vectors++; if (iss_n.size() != 2) begin miscompares++; $display("FAIL ab_issued: got %0d want 2", iss_n.size()); end
    vectors++; if (scanned !== 33'd2) begin miscompares++; $display("FAIL ab_scanned: got %0d want 2", scanned); end
    vectors++; if (got_n.size() != 2) begin miscompares++; $display("FAIL ab_results: got %0d want 2", got_n.size()); end
  endtask

  task automatic test_reset_mid_job();
    start_job(32'd3000, 32'd50, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rm_ready: got %b want 1", ready); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rm_res_valid: got %b want 0", res_valid); end
    vectors++; if (perm_in_valid !== 1'b0) begin miscompares++; $display("FAIL rm_perm_in_valid: got %b want 0", perm_in_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (12) @(negedge clk);
    vectors++; if (got_n.size() != 0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL rm_no_push: got %0d pops res_valid=%b want 0", got_n.size(), res_valid); end
    vectors++; if (scanned !== 33'd0) begin miscompares++; $display("FAIL rm_scanned: got %0d want 0", scanned); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stop_on_first = 1'b0;
    start_nonce = '0; nonce_count = '0; threshold = '0; res_ready = 1'b1;
    for (int k = 0; k < 24; k++) hdr[k] = 32'h1000_0000 + 32'(k);
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_collect_all();
    test_no_hits();
    test_threshold_boundary();
    test_stop_first();
    test_overflow();
    test_wrap();
    test_abort();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sha3_range_scanner.md
# sha3_range_scanner

Parametrised successor to the single-shot SHA3 nonce scanner. It captures a 24-word header, issues one candidate state per cycle over a bounded nonce range [start_nonce, start_nonce+nonce_count) into an external in-order, fixed-latency Keccak-f[1600] pipeline, and compares each returned digest against a threshold. Hits go into a RESULT_DEPTH-entry result FIFO, with either stop-on-first or collect-all behaviour and an abort input. It sits between the host/job registers and the `sha3` hasher.

## Interface
- RESULT_DEPTH, 4, result FIFO entries; power of two, ≥2
- HASH_LANES, 4, number of leading 64-bit output lanes stored per result (1..25)
- DOMAIN_PAD, 32'h00000006, upper 32 bits of state lane 12
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job request; accepted only when ready=1
- abort  in  1  stop issuing new nonces; in-flight work still drains
- stop_on_first  in  1  sampled at accept; 1 = stop at first hit
- header  in  32×24  header words; lane i = {header[2i+1], header[2i]}, i=0..11
- start_nonce  in  32  first nonce
- nonce_count  in  32  nonces to scan; 0 means 2^32
- threshold  in  64  hit when difficulty < threshold (unsigned)
- perm_in_valid  out  1  state valid to hasher
- perm_in_state  out  64×25  lanes 0..24
- perm_out_valid  in  1  hasher result valid, same order as issue
- perm_out_state  in  64×25  hasher output lanes
- ready  out  1  IDLE state
- busy  out  1  ~ready
- done  out  1  one-cycle pulse on job completion
- overflow  out  1  sticky: a hit was dropped because the FIFO was full
- scanned  out  33  results evaluated in the current or last job
- res_valid / res_ready  out / in  1 / 1  result FIFO pop handshake
- res_nonce  out  32  head entry nonce
- res_hash  out  64×HASH_LANES  head entry lanes 0..HASH_LANES-1

## Operation
- States: IDLE, DISPATCH, DRAIN.
- IDLE → DISPATCH on start.
  - Capture header, start_nonce, count (0 → 2^32), threshold, stop_on_first.
  - Clear issued, scanned, overflow and the hit flag.
- DISPATCH: each cycle assert perm_in_valid with the following state:
  - lanes 0..11 from the header.
  - lane 12 = {DOMAIN_PAD, nonce}.
  - lane 16 = 64'h80000000_00000000.
  - all other lanes 0.
  - nonce = start_nonce + issued, mod 2^32, so it wraps.
- DISPATCH → DRAIN when any of the following holds; no issue occurs on that cycle:
  - issued == count
  - abort
  - overflow
  - stop_on_first & hit flag
- DRAIN → IDLE when scanned == issued. done pulses on that transition.
- Evaluation, on each perm_out_valid outside IDLE:
  - difficulty = byte-reversed lane 0 (lane0[7:0] becomes MSB).
  - Result nonce = start_nonce + scanned, mod 2^32.
  - scanned increments.
- On a hit:
  - collect-all: push to the FIFO if not full; if full, set overflow and drop the hit.
  - stop_on_first: push only the first hit, then set the hit flag; later hits are discarded.
- perm_out_valid is ignored in IDLE, which covers stale pipeline contents after reset or abort.
- The result FIFO is not cleared on start; the consumer drains it. A pop happens on res_valid & res_ready.
- A simultaneous push and pop on a full FIFO is allowed: the push succeeds and overflow is not set.
- start when not ready is ignored. abort in IDLE has no effect.

## Timing
- Reset values: ready=1, busy=0, done=0, overflow=0, scanned=0, res_valid=0, perm_in_valid=0. All FIFO pointers are 0.
- Accept at edge N. The first perm_in_valid is in cycle N+1, then one per cycle with no bubbles.
- abort sampled high at edge M: no perm_in_valid from cycle M+1 onward.
- A hit on perm_out_valid at edge K gives res_valid=1 from cycle K+1.
- scanned updates at the same edge as the hit.
- done is asserted in the cycle after the edge where the last result is evaluated. ready=1 in the same cycle.
- With hasher latency L and count C, with no early stop: done is asserted in cycle N+C+L+1, relative to accept edge N.
- Asynchronous reset mid-job: outputs take reset values immediately, the job is lost, and FIFO contents are lost.

## Test plan
- threshold=64'hFFFF_FFFF_FFFF_FFFF, count=3, start_nonce=100, collect-all, stub L=5, res_ready=1 → results nonce 100, 101, 102 in order; scanned=3; single done pulse; overflow=0.
- threshold=0, count=10 → no res_valid; scanned=10; done exactly once.
- stop_on_first=1, threshold all-ones, count=100, L=5 → exactly one result (nonce=start_nonce); issued ≤ 7; scanned == issued at done.
- RESULT_DEPTH=4, count=6, all hits, res_ready=0 → 4 entries; overflow=1; dispatch halts; then popping yields nonces start..start+3.
- start_nonce=32'hFFFFFFFE, count=4, all hits → nonces FFFFFFFE, FFFFFFFF, 00000000, 00000001; lane 12 low word matches on issue.
- rst_n low during DISPATCH, stub still emitting perm_out_valid → ready=1 and res_valid=0 immediately; no pushes after reset release.
